// File: rtl/far_mem_responder.sv
// far_mem_responder: far-memory stand-in behind the cache FM port.
// Accepts line writes (no response) and line reads that return in request
// order after a per-request programmable latency, at most one per cycle.
module far_mem_responder #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128,
  parameter int ID_W   = 4,
  parameter int MEM_AW = 8,
  parameter int QDEPTH = 8,
  parameter int LAT_W  = 4,
  parameter int TS_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_req_valid,
  input  logic [ADDR_W-1:0]         rd_req_address,
  input  logic [ID_W-1:0]           rd_req_tq_id,
  input  logic                      wr_req_valid,
  input  logic [ADDR_W-1:0]         wr_req_address,
  input  logic [LINE_W-1:0]         wr_req_data,
  input  logic [LAT_W-1:0]          cfg_latency,
  output logic                      rd_rsp_valid,
  output logic [ADDR_W-1:0]         rd_rsp_address,
  output logic [ID_W-1:0]           rd_rsp_tq_id,
  output logic [LINE_W-1:0]         rd_rsp_data,
  output logic [$clog2(QDEPTH):0]   pending_cnt,
  output logic                      ovf_err
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  // Backing store and pending-read FIFO storage (never reset)
  logic [LINE_W-1:0] r_mem    [2**MEM_AW];
  logic [ADDR_W-1:0] r_q_addr [QDEPTH];
  logic [ID_W-1:0]   r_q_id   [QDEPTH];
  logic [TS_W-1:0]   r_q_due  [QDEPTH];

  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [TS_W-1:0]   r_now;
  logic              r_ovf;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_rsp_address;
  logic [ID_W-1:0]   r_rsp_tq_id;
  logic [LINE_W-1:0] r_rsp_data;

  logic [LAT_W-1:0]  w_lat_eff;
  logic [TS_W-1:0]   w_due;
  logic [TS_W-1:0]   w_age;
  logic [ADDR_W-1:0] w_head_addr;
  logic [MEM_AW-1:0] w_head_idx;
  logic [MEM_AW-1:0] w_wr_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_unused_addr_hi;

  assign w_lat_eff   = (cfg_latency == '0) ? LAT_W'(1) : cfg_latency;
  assign w_due       = r_now + TS_W'(w_lat_eff);
  assign w_head_addr = r_q_addr[r_rptr];
  assign w_head_idx  = w_head_addr[MEM_AW-1:0];
  assign w_wr_idx    = wr_req_address[MEM_AW-1:0];
  assign w_age       = r_now - r_q_due[r_rptr];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(QDEPTH));
  // Head is due once (now - due) is non-negative in wrap-safe arithmetic
  assign w_pop       = !w_empty && !w_age[TS_W-1];
  // A same-cycle pop frees a slot, so a full FIFO still accepts
  assign w_push      = rd_req_valid && (!w_full || w_pop);

  assign w_unused_addr_hi = ^{wr_req_address[ADDR_W-1:MEM_AW]};

  assign rd_rsp_valid   = r_rsp_valid;
  assign rd_rsp_address = r_rsp_address;
  assign rd_rsp_tq_id   = r_rsp_tq_id;
  assign rd_rsp_data    = r_rsp_data;
  assign pending_cnt    = r_count;
  assign ovf_err        = r_ovf;

  // Line write-back into the backing array; always accepted
  always_ff @(posedge clk) begin
    if (wr_req_valid) begin
      r_mem[w_wr_idx] <= wr_req_data;
    end
  end

  // FIFO entry capture at the write pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wptr] <= rd_req_address;
      r_q_id[r_wptr]   <= rd_req_tq_id;
      r_q_due[r_wptr]  <= w_due;
    end
  end

  // Timestamp, FIFO control, overflow flag and registered response
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_now         <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_ovf         <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_address <= '0;
      r_rsp_tq_id   <= '0;
      r_rsp_data    <= '0;
    end else begin
      r_now       <= r_now + TS_W'(1);
      r_rsp_valid <= w_pop;
      if (w_pop) begin
        r_rsp_address <= w_head_addr;
        r_rsp_tq_id   <= r_q_id[r_rptr];
        r_rsp_data    <= r_mem[w_head_idx];
        r_rptr        <= r_rptr + PW'(1);
      end
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (rd_req_valid && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/far_mem_responder.md
# far_mem_responder

Far-memory (FM) responder model that sits at the memory end of the cache's FM interface. It accepts the cache's read-miss requests and dirty-evict write-back requests and returns whole cache lines after a programmable latency. Responses return in request order, at most one per cycle. The block is used as the FM stand-in for cache-level simulation and for FPGA bring-up below the cache.

## Interface
Parameters:
- ADDR_W, 20: line-address width (byte offset already stripped).
- LINE_W, 128: cache-line data width.
- ID_W, 4: TQ-entry id width, echoed in responses.
- MEM_AW, 8: index width of the backing array (2^MEM_AW lines).
- QDEPTH, 8: pending-read queue depth (power of 2).
- LAT_W, 4: width of cfg_latency.
- TS_W, 8: width of the free-running timestamp counter; must satisfy 2^(TS_W-1) > 2^LAT_W.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-low reset; the block is in reset when rst==0 at the clock edge.
- rd_req_valid, input, 1: read request this cycle (cache miss).
- rd_req_address, input, ADDR_W: requested line address.
- rd_req_tq_id, input, ID_W: requester TQ id.
- wr_req_valid, input, 1: write-back request this cycle (dirty evict).
- wr_req_address, input, ADDR_W: write line address.
- wr_req_data, input, LINE_W: full line to write.
- cfg_latency, input, LAT_W: read latency in cycles, sampled per request. A value of 0 is treated as 1.
- rd_rsp_valid, output, 1: read response valid. Single-cycle pulse per response; there is no ready signal.
- rd_rsp_address, output, ADDR_W: echoed request address.
- rd_rsp_tq_id, output, ID_W: echoed request id.
- rd_rsp_data, output, LINE_W: line data.
- pending_cnt, output, $clog2(QDEPTH)+1: number of queued, not-yet-answered reads.
- ovf_err, output, 1: sticky; set when a read was dropped because the queue was full.

## Operation
- Backing array: 2^MEM_AW x LINE_W lines, indexed by rd/wr address[MEM_AW-1:0]. Upper address bits are ignored (aliasing is allowed). Array contents are not cleared by reset.
- Write: when wr_req_valid=1, the line is written at the clock edge. Writes are always accepted and produce no response.
- Timestamp: a TS_W-bit counter `now` increments every cycle and wraps freely.
- Read accept: when rd_req_valid=1, an entry {address, tq_id, due = now + max(cfg_latency,1)} is pushed into the in-order FIFO. The due computation is mod 2^TS_W.
- Issue condition: the head entry issues when the FIFO is non-empty and (now - due) mod 2^TS_W has MSB=0, i.e. now has reached due, wrap-safe. At most one entry issues per cycle.
- Issue: the head is popped and a registered response is formed from {head address, head tq_id, array[head index]}. The array is read using its state before this edge's write, so there is no write-to-read bypass on the same cycle.
- Ordering: responses are strictly in request order. A later request with a shorter latency waits behind the head and issues on the first cycle after the head issues in which its own due time has also been reached.
- Full: if the FIFO holds QDEPTH entries, no pop occurs this cycle, and rd_req_valid=1, the request is dropped and ovf_err is set. ovf_err clears only on reset.
- Simultaneous pop and push when full: the pop frees a slot, so the push is accepted and pending_cnt is unchanged.
- Simultaneous read and write to the same index in one cycle: the write lands, and the read entry later returns the array state at its issue time.

## Timing
- Reset values (rst==0 at an edge): rd_rsp_valid=0, rd_rsp_address=0, rd_rsp_tq_id=0, rd_rsp_data=0, pending_cnt=0, ovf_err=0, now=0, FIFO pointers=0. All in-flight reads are discarded when reset is asserted mid-operation, and none of them produce a response after reset.
- Latency: a read sampled at edge T with latency L, into an empty FIFO, produces rd_rsp_valid=1 during the cycle that follows edge T+L.
- rd_rsp_valid is high for exactly one cycle per issued response. The response fields hold their last values while rd_rsp_valid=0.
- A write sampled at edge T is visible to any read that issues at edge T+1 or later.
- Throughput: one read accepted and one response issued per cycle, sustained.

## Test plan
- Basic: write 0xA5 pattern to line 0x10 at cycle 0; read 0x10 with id 3 and cfg_latency=4 at cycle 2 -> a single rd_rsp_valid pulse after edge 6 carrying address 0x10, id 3, data 0xA5 pattern.
- Ordering: read A with latency 8, then read B with latency 1 on the next cycle -> A is answered after edge 8 and B after edge 9, in order, one per cycle.
- Overflow: cfg_latency=15, 9 back-to-back reads with QDEPTH=8 -> 9th dropped, ovf_err=1, pending_cnt=8, exactly 8 responses returned.
- Full plus pop: with the FIFO full and the head due on the same cycle as a new read -> the new read is accepted, pending_cnt stays 8, and ovf_err stays 0.
- Timestamp wrap: run 250 idle cycles, then issue reads with latency 10 across the wrap of `now` -> each response arrives exactly 10 cycles after its request.
- Reset mid-flight: 3 reads pending, rst=0 for one edge -> all outputs are 0 after reset and no responses ever return for those 3 reads.
